// File: rtl/rob_pkg.sv
// Shared types and helpers for the reorder buffer: default widths, the entry record
// and the tag/index mapping (entry i carries tag i+1, tag 0 means "no producer").
package rob_pkg;

    localparam int TAG_W = 8;
    localparam int XLEN = 32;
    localparam logic [TAG_W-1:0] NO_TAG = '0;

    typedef struct packed {
        logic            busy;
        logic            done;
        logic            mispredict;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
        logic [XLEN-1:0] target;
    } rob_entry_t;

    // Only meaningful for tags already known to be in 1..DEPTH.
    function automatic int tag_to_idx(input logic [TAG_W-1:0] tag);
        return int'(tag) - 1;
    endfunction

endpackage

// File: rtl/rob_lookup.sv
// Operand lookup for one read port: the CDB bypass wins over the captured entry data,
// and tag 0 is always ready with a zero value.
module rob_lookup
    import rob_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic [TAG_W-1:0] q_tag,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [XLEN-1:0]  cdb_data,
    input  rob_entry_t       entries [DEPTH],
    output logic             ready,
    output logic [XLEN-1:0]  data
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic             in_range;
    logic [IDX_W-1:0] idx;
    rob_entry_t       ent;

    assign in_range = (q_tag != NO_TAG) && (q_tag <= TAG_W'(DEPTH));
    assign idx = IDX_W'(tag_to_idx(q_tag));
    assign ent = entries[idx];

    always_comb begin
        ready = 1'b0;
        data = '0;
        if (q_tag == NO_TAG) begin
            ready = 1'b1;
        end else if (cdb_valid && cdb_tag == q_tag) begin
            ready = 1'b1;
            data = cdb_data;
        end else if (in_range && ent.busy && ent.done) begin
            ready = 1'b1;
            data = ent.data;
        end
    end

endmodule

// File: rtl/rob.sv
// Reorder buffer: hands out rename tags at issue, captures CDB results, retires
// in program order onto the commit bus and pulses br on a mispredicted retirement.
module rob
    import rob_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int TAG_W = 8,
    parameter int XLEN = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_valid,
    input  logic [4:0]       alloc_rd,
    output logic             alloc_ready,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [XLEN-1:0]  cdb_data,
    input  logic             cdb_mispredict,
    input  logic [XLEN-1:0]  cdb_target,
    input  logic [TAG_W-1:0] q1_tag,
    input  logic [TAG_W-1:0] q2_tag,
    output logic             q1_ready,
    output logic             q2_ready,
    output logic [XLEN-1:0]  q1_data,
    output logic [XLEN-1:0]  q2_data,
    output logic             ROB_we,
    output logic [4:0]       reg_addr,
    output logic [XLEN-1:0]  reg_data,
    output logic [TAG_W-1:0] reg_tag,
    output logic             br,
    output logic [XLEN-1:0]  br_target
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rob_entry_t       entries [DEPTH];
    logic [IDX_W-1:0] head;
    logic [IDX_W-1:0] tail;
    logic [IDX_W:0]   count;

    rob_entry_t       head_ent;
    logic             commit;
    logic             flush_now;
    logic             do_alloc;
    logic             cdb_hit;
    logic [IDX_W-1:0] cdb_idx;

    assign head_ent = entries[head];
    assign commit = head_ent.busy && head_ent.done;
    assign flush_now = commit && head_ent.mispredict;

    // Full is judged on registered count, so a same-cycle commit frees its slot one cycle later.
    assign alloc_ready = (count < (IDX_W+1)'(DEPTH)) && !br && !flush_now;
    assign alloc_tag = TAG_W'(tail) + TAG_W'(1);
    assign do_alloc = alloc_valid && alloc_ready;

    assign cdb_idx = IDX_W'(tag_to_idx(cdb_tag));
    assign cdb_hit = cdb_valid && (cdb_tag != NO_TAG) && (cdb_tag <= TAG_W'(DEPTH))
                     && entries[cdb_idx].busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
            head <= '0;
            tail <= '0;
            count <= '0;
            ROB_we <= 1'b0;
            reg_addr <= '0;
            reg_data <= '0;
            reg_tag <= '0;
            br <= 1'b0;
            br_target <= '0;
        end else begin
            ROB_we <= commit;
            br <= flush_now;
            if (commit) begin
                reg_addr <= head_ent.rd;
                reg_data <= head_ent.data;
                reg_tag <= TAG_W'(head) + TAG_W'(1);
            end
            if (flush_now) begin
                // Younger work is discarded wholesale, including any result on the CDB now.
                br_target <= head_ent.target;
                for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
                head <= '0;
                tail <= '0;
                count <= '0;
            end else begin
                if (cdb_hit) begin
                    entries[cdb_idx].done <= 1'b1;
                    entries[cdb_idx].data <= cdb_data;
                    entries[cdb_idx].mispredict <= cdb_mispredict;
                    entries[cdb_idx].target <= cdb_target;
                end
                if (commit) begin
                    entries[head].busy <= 1'b0;
                    entries[head].done <= 1'b0;
                    head <= head + IDX_W'(1);
                end
                if (do_alloc) begin
                    entries[tail].busy <= 1'b1;
                    entries[tail].done <= 1'b0;
                    entries[tail].mispredict <= 1'b0;
                    entries[tail].rd <= alloc_rd;
                    tail <= tail + IDX_W'(1);
                end
                count <= count + (IDX_W+1)'(do_alloc) - (IDX_W+1)'(commit);
            end
        end
    end

    rob_lookup #(.DEPTH(DEPTH)) u_lookup_q1 (
        .q_tag     (q1_tag),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .entries   (entries),
        .ready     (q1_ready),
        .data      (q1_data)
    );

    rob_lookup #(.DEPTH(DEPTH)) u_lookup_q2 (
        .q_tag     (q2_tag),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .entries   (entries),
        .ready     (q2_ready),
        .data      (q2_data)
    );

endmodule

// File: tb/tb_rob.sv
// Directed bench for the reorder buffer: allocation, in-order commit, full/wrap,
// mispredict flush, operand lookup and mid-operation reset.
module tb_rob;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alloc_valid = 1'b0;
    logic [4:0]  alloc_rd = '0;
    logic        alloc_ready;
    logic [7:0]  alloc_tag;
    logic        cdb_valid = 1'b0;
    logic [7:0]  cdb_tag = '0;
    logic [31:0] cdb_data = '0;
    logic        cdb_mispredict = 1'b0;
    logic [31:0] cdb_target = '0;
    logic [7:0]  q1_tag = '0;
    logic [7:0]  q2_tag = '0;
    logic        q1_ready, q2_ready;
    logic [31:0] q1_data, q2_data;
    logic        ROB_we;
    logic [4:0]  reg_addr;
    logic [31:0] reg_data;
    logic [7:0]  reg_tag;
    logic        br;
    logic [31:0] br_target;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rob #(.DEPTH(8), .TAG_W(8), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .cdb_mispredict(cdb_mispredict), .cdb_target(cdb_target),
        .q1_tag(q1_tag), .q2_tag(q2_tag),
        .q1_ready(q1_ready), .q2_ready(q2_ready),
        .q1_data(q1_data), .q2_data(q2_data),
        .ROB_we(ROB_we), .reg_addr(reg_addr), .reg_data(reg_data), .reg_tag(reg_tag),
        .br(br), .br_target(br_target)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alloc_valid = 1'b0;
        alloc_rd = '0;
        cdb_valid = 1'b0;
        cdb_tag = '0;
        cdb_data = '0;
        cdb_mispredict = 1'b0;
        cdb_target = '0;
        q1_tag = '0;
        q2_tag = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (ROB_we !== 1'b0) begin n_err++; $display("FAIL reset_we got=%b exp=0", ROB_we); end
        n_cmp++; if (br !== 1'b0) begin n_err++; $display("FAIL reset_br got=%b exp=0", br); end
        n_cmp++; if ({reg_addr, reg_data, reg_tag, br_target} !== '0) begin n_err++;
            $display("FAIL reset_regs got addr=%h data=%h tag=%h tgt=%h exp=0", reg_addr, reg_data, reg_tag, br_target); end
        n_cmp++; if (alloc_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b exp=1", alloc_ready); end
        n_cmp++; if (alloc_tag !== 8'd1) begin n_err++; $display("FAIL reset_tag got=%0d exp=1", alloc_tag); end
    endtask

    task automatic test_single();
        do_reset();
        alloc_valid = 1'b1; alloc_rd = 5'd5;
        #1;
        n_cmp++; if (alloc_tag !== 8'd1) begin n_err++; $display("FAIL single_tag got=%0d exp=1", alloc_tag); end
        step();
        alloc_valid = 1'b0;
        cdb_valid = 1'b1; cdb_tag = 8'd1; cdb_data = 32'hDEAD;
        step();
        cdb_valid = 1'b0;
        n_cmp++; if (ROB_we !== 1'b0) begin n_err++; $display("FAIL single_early_we got=%b exp=0", ROB_we); end
        step();
        n_cmp++; if ({ROB_we, reg_addr, reg_data, reg_tag} !== {1'b1, 5'd5, 32'hDEAD, 8'd1}) begin n_err++;
            $display("FAIL single_commit got we=%b addr=%0d data=%h tag=%0d exp we=1 addr=5 data=dead tag=1",
                     ROB_we, reg_addr, reg_data, reg_tag); end
        step();
        n_cmp++; if (ROB_we !== 1'b0) begin n_err++; $display("FAIL single_we_pulse got=%b exp=0", ROB_we); end
    endtask

    task automatic test_in_order();
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            alloc_valid = 1'b1; alloc_rd = 5'(k);
            #1;
            n_cmp++; if (alloc_tag !== 8'(k)) begin n_err++; $display("FAIL order_alloc_tag got=%0d exp=%0d", alloc_tag, k); end
            step();
        end
        alloc_valid = 1'b0;
        for (int k = 3; k >= 1; k--) begin
            cdb_valid = 1'b1; cdb_tag = 8'(k); cdb_data = 32'(100 + k);
            step();
            n_cmp++; if (ROB_we !== 1'b0) begin n_err++; $display("FAIL order_early_we tag=%0d got=%b exp=0", k, ROB_we); end
        end
        cdb_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            n_cmp++; if ({ROB_we, reg_tag, reg_addr, reg_data} !== {1'b1, 8'(k), 5'(k), 32'(100 + k)}) begin n_err++;
                $display("FAIL order_commit got we=%b tag=%0d addr=%0d data=%0d exp we=1 tag=%0d addr=%0d data=%0d",
                         ROB_we, reg_tag, reg_addr, reg_data, k, k, 100 + k); end
        end
        step();
        n_cmp++; if (ROB_we !== 1'b0) begin n_err++; $display("FAIL order_drain got=%b exp=0", ROB_we); end
    endtask

    task automatic test_full_wrap();
        do_reset();
        alloc_valid = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            alloc_rd = 5'(k);
            #1;
            n_cmp++; if (alloc_tag !== 8'(k) || alloc_ready !== 1'b1) begin n_err++;
                $display("FAIL full_alloc got tag=%0d ready=%b exp tag=%0d ready=1", alloc_tag, alloc_ready, k); end
            step();
        end
        alloc_rd = 5'd20;
        n_cmp++; if (alloc_ready !== 1'b0) begin n_err++; $display("FAIL full_ready got=%b exp=0", alloc_ready); end
        step();
        n_cmp++; if (alloc_ready !== 1'b0 || alloc_tag !== 8'd1) begin n_err++;
            $display("FAIL full_hold got ready=%b tag=%0d exp ready=0 tag=1", alloc_ready, alloc_tag); end
        cdb_valid = 1'b1; cdb_tag = 8'd1; cdb_data = 32'h55;
        step();
        cdb_valid = 1'b0;
        n_cmp++; if (alloc_ready !== 1'b0) begin n_err++; $display("FAIL full_commit_cycle got=%b exp=0", alloc_ready); end
        step();
        n_cmp++; if ({ROB_we, reg_tag} !== {1'b1, 8'd1}) begin n_err++;
            $display("FAIL full_commit got we=%b tag=%0d exp we=1 tag=1", ROB_we, reg_tag); end
        n_cmp++; if (alloc_ready !== 1'b1 || alloc_tag !== 8'd1) begin n_err++;
            $display("FAIL full_wrap got ready=%b tag=%0d exp ready=1 tag=1", alloc_ready, alloc_tag); end
        step();
        alloc_valid = 1'b0;
        #1;
        n_cmp++; if (alloc_ready !== 1'b0 || alloc_tag !== 8'd2) begin n_err++;
            $display("FAIL full_refill got ready=%b tag=%0d exp ready=0 tag=2", alloc_ready, alloc_tag); end
    endtask

    task automatic test_flush();
        do_reset();
        alloc_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            alloc_rd = 5'(k);
            step();
        end
        alloc_valid = 1'b0;
        cdb_valid = 1'b1; cdb_tag = 8'd2; cdb_data = 32'h22; cdb_mispredict = 1'b1; cdb_target = 32'h40;
        step();
        cdb_tag = 8'd1; cdb_data = 32'h11; cdb_mispredict = 1'b0; cdb_target = 32'h0;
        step();
        cdb_tag = 8'd3; cdb_data = 32'h33;
        n_cmp++; if (alloc_ready !== 1'b1) begin n_err++; $display("FAIL flush_pre_ready got=%b exp=1", alloc_ready); end
        step();
        cdb_tag = 8'd4; cdb_data = 32'h44;
        n_cmp++; if ({ROB_we, reg_tag, reg_data, br} !== {1'b1, 8'd1, 32'h11, 1'b0}) begin n_err++;
            $display("FAIL flush_tag1 got we=%b tag=%0d data=%h br=%b exp we=1 tag=1 data=11 br=0", ROB_we, reg_tag, reg_data, br); end
        n_cmp++; if (alloc_ready !== 1'b0) begin n_err++; $display("FAIL flush_now_ready got=%b exp=0", alloc_ready); end
        step();
        cdb_valid = 1'b0;
        n_cmp++; if ({ROB_we, reg_tag, reg_addr, reg_data} !== {1'b1, 8'd2, 5'd2, 32'h22}) begin n_err++;
            $display("FAIL flush_tag2 got we=%b tag=%0d addr=%0d data=%h exp we=1 tag=2 addr=2 data=22", ROB_we, reg_tag, reg_addr, reg_data); end
        n_cmp++; if ({br, br_target} !== {1'b1, 32'h40}) begin n_err++;
            $display("FAIL flush_br got br=%b tgt=%h exp br=1 tgt=40", br, br_target); end
        n_cmp++; if (alloc_ready !== 1'b0 || alloc_tag !== 8'd1) begin n_err++;
            $display("FAIL flush_br_ready got ready=%b tag=%0d exp ready=0 tag=1", alloc_ready, alloc_tag); end
        step();
        n_cmp++; if ({br, ROB_we, alloc_ready, alloc_tag} !== {1'b0, 1'b0, 1'b1, 8'd1}) begin n_err++;
            $display("FAIL flush_after got br=%b we=%b ready=%b tag=%0d exp br=0 we=0 ready=1 tag=1", br, ROB_we, alloc_ready, alloc_tag); end
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++; if (ROB_we !== 1'b0) begin n_err++; $display("FAIL flush_squashed cyc=%0d got=%b exp=0", k, ROB_we); end
        end
    endtask

    task automatic test_lookup();
        do_reset();
        alloc_valid = 1'b1;
        alloc_rd = 5'd1; step();
        alloc_rd = 5'd2; step();
        alloc_valid = 1'b0;
        q1_tag = 8'd2; q2_tag = 8'd1;
        #1;
        n_cmp++; if ({q1_ready, q1_data} !== {1'b0, 32'd0}) begin n_err++;
            $display("FAIL lookup_pending got rdy=%b data=%0d exp rdy=0 data=0", q1_ready, q1_data); end
        cdb_valid = 1'b1; cdb_tag = 8'd2; cdb_data = 32'd7;
        #1;
        n_cmp++; if ({q1_ready, q1_data} !== {1'b1, 32'd7}) begin n_err++;
            $display("FAIL lookup_bypass got rdy=%b data=%0d exp rdy=1 data=7", q1_ready, q1_data); end
        n_cmp++; if ({q2_ready, q2_data} !== {1'b0, 32'd0}) begin n_err++;
            $display("FAIL lookup_other got rdy=%b data=%0d exp rdy=0 data=0", q2_ready, q2_data); end
        step();
        cdb_valid = 1'b0; cdb_data = 32'd99;
        q1_tag = 8'd0; q2_tag = 8'd2;
        #1;
        n_cmp++; if ({q1_ready, q1_data} !== {1'b1, 32'd0}) begin n_err++;
            $display("FAIL lookup_tag0 got rdy=%b data=%0d exp rdy=1 data=0", q1_ready, q1_data); end
        n_cmp++; if ({q2_ready, q2_data} !== {1'b1, 32'd7}) begin n_err++;
            $display("FAIL lookup_entry got rdy=%b data=%0d exp rdy=1 data=7", q2_ready, q2_data); end
        q1_tag = 8'd9;
        #1;
        n_cmp++; if ({q1_ready, q1_data} !== {1'b0, 32'd0}) begin n_err++;
            $display("FAIL lookup_range got rdy=%b data=%0d exp rdy=0 data=0", q1_ready, q1_data); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        alloc_valid = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            alloc_rd = 5'(k);
            step();
        end
        alloc_valid = 1'b0;
        cdb_valid = 1'b1; cdb_tag = 8'd1; cdb_data = 32'hAA; cdb_mispredict = 1'b1; cdb_target = 32'h80;
        step();
        idle_inputs();
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if ({ROB_we, br} !== 2'b00) begin n_err++; $display("FAIL rstmid_async got we=%b br=%b exp 00", ROB_we, br); end
        step();
        n_cmp++; if ({ROB_we, br} !== 2'b00) begin n_err++; $display("FAIL rstmid_hold got we=%b br=%b exp 00", ROB_we, br); end
        rst = 1'b0;
        #1;
        n_cmp++; if (alloc_tag !== 8'd1 || alloc_ready !== 1'b1) begin n_err++;
            $display("FAIL rstmid_tag got tag=%0d ready=%b exp tag=1 ready=1", alloc_tag, alloc_ready); end
        for (int k = 0; k < 2; k++) begin
            step();
            n_cmp++; if ({ROB_we, br} !== 2'b00) begin n_err++; $display("FAIL rstmid_after cyc=%0d got we=%b br=%b exp 00", k, ROB_we, br); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_in_order();
        test_full_wrap();
        test_flush();
        test_lookup();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rob.md
Name: rob

Overview:
- Reorder buffer for the Tomasulo core.
- Allocates rename tags to instructions at issue and captures results from the common data bus (CDB).
- Retires entries in program order, producing the register-file commit bus (ROB_we/reg_addr/reg_data/reg_tag) and the branch flush pulse (br) that clears register locks.
- Tag 0 means "no producer"; entry i carries tag i+1.

Parameters:
- DEPTH, 8, number of entries; power of two, 2..128.
- TAG_W, 8, rename tag width.
- XLEN, 32, data width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- alloc_valid  in  1  decoder requests an entry
- alloc_rd  in  5  destination register (0 = none)
- alloc_ready  out  1  entry available this cycle
- alloc_tag  out  TAG_W  tag granted: tail+1, combinational
- cdb_valid  in  1  result broadcast
- cdb_tag  in  TAG_W  producer tag
- cdb_data  in  XLEN  result
- cdb_mispredict  in  1  producer is a mispredicted control-flow instruction
- cdb_target  in  XLEN  correct PC for the mispredict
- q1_tag, q2_tag  in  TAG_W  operand lookup tags (from register-file lock outputs)
- q1_ready, q2_ready  out  1  operand value available
- q1_data, q2_data  out  XLEN  operand value
- ROB_we  out  1  commit write strobe
- reg_addr  out  5  commit destination
- reg_data  out  XLEN  commit value
- reg_tag  out  TAG_W  committing tag
- br  out  1  one-cycle flush pulse
- br_target  out  XLEN  redirect PC, valid while br=1

Behaviour:
- State:
  - head and tail pointers (log2 DEPTH bits, wrap modulo DEPTH).
  - count (0..DEPTH).
  - Per entry: busy, done, mispredict, rd, data, target.
- Reset (async):
  - head=tail=count=0; all busy/done/mispredict cleared.
  - ROB_we=0, br=0, reg_addr=0, reg_data=0, reg_tag=0, br_target=0.
  - alloc_ready becomes 1 after reset.
- Allocate:
  - alloc_ready = (count<DEPTH) && !br && !flush_now.
  - On alloc_valid && alloc_ready: entry[tail] gets busy=1, done=0, mispredict=0, rd=alloc_rd; tail+1; count+1.
  - alloc_tag = tail+1 is valid in the same cycle.
  - A slot freed by a commit in the same cycle does not raise alloc_ready until the next cycle.
- CDB capture:
  - On cdb_valid with 1<=cdb_tag<=DEPTH and the entry busy: set done=1 and latch data, mispredict and target.
  - Tag 0, an out-of-range tag, or a non-busy entry: ignored.
- Commit: one entry per cycle, decided on registered state. There is no same-cycle CDB-to-commit bypass.
  - If entry[head] is busy && done:
    - Next edge: ROB_we<=1, reg_addr<=rd, reg_data<=data, reg_tag<=head+1.
    - Clear busy; head+1; count-1.
    - rd=0 still pulses ROB_we; the register file ignores address 0.
  - Otherwise ROB_we<=0.
  - Minimum latency: CDB captured at edge E, ROB_we high in the cycle after edge E+1.
- Flush:
  - flush_now = head busy && done && mispredict.
  - That entry commits normally (its rd is written).
  - At the same edge: br<=1 and br_target<=target; all entries cleared; head=tail=count=0.
  - br is high exactly one cycle; no allocation while flush_now or br is high.
  - A CDB result arriving during the flush cycle is discarded.
- Simultaneous events:
  - alloc + CDB + commit in one cycle all apply.
  - count changes by (alloc - commit).
- Lookup (combinational, per port):
  - Tag 0: ready=1, data=0.
  - cdb_valid && cdb_tag==q_tag: ready=1, data=cdb_data (CDB bypass).
  - Entry busy && done: ready=1, data=entry data.
  - Otherwise ready=0, data=0.
- Full/empty:
  - Full: alloc_ready=0; alloc_valid is held by the requester with no side effects.
  - Empty: no commit; ROB_we=0.
- Reset mid-operation discards all in-flight entries with no commit pulse.

Decomposition:
- Shared package holds:
  - TAG_W, XLEN, NO_TAG=0
  - the rob_entry_t struct (busy, done, mispredict, rd, data, target)
  - a tag-to-index conversion function
- One sub-module, rob_lookup: combinational tag lookup with CDB bypass, instantiated twice (q1, q2).

Test Plan:
- Reset, alloc rd=5 -> alloc_tag=1. CDB tag1 data=0xDEAD -> two edges later ROB_we=1, reg_addr=5, reg_data=0xDEAD, reg_tag=1 for one cycle.
- Alloc rd=1,2,3 (tags 1,2,3); CDB tag3 then tag2 then tag1 -> commits in order tag1,2,3 on consecutive cycles.
- Allocate 8 with no CDB -> alloc_ready=0, count=8. Complete head -> alloc_ready returns 1 the cycle after commit, next alloc_tag=1 (wrap).
- Alloc tags 1..4; CDB tag2 mispredict target=0x40; complete tag1 -> tag1 and tag2 commit. br=1 with br_target=0x40 for one cycle; tags 3,4 never commit; next alloc_tag=1.
- q1_tag=2 pending, CDB tag2 data=7 same cycle -> q1_ready=1, q1_data=7. q1_tag=0 -> q1_ready=1, q1_data=0.
- Assert rst while 3 entries busy -> ROB_we and br stay 0; alloc_tag=1 after release.
